// File: rtl/ab_policy_recovery_scheduler_if.sv
// Bus between the two policy enforcers, the scheduler and the transition blocks.
// master: drives tick, raw channel and policy edits/refs; samples the arbitrated result.
// slave : the scheduler; samples inputs and drives A_ctp_out/B_ctp_out, out_valid,
//         grant, conflict, conflict_count.
interface ab_policy_recovery_scheduler_if #(
    parameter int unsigned REF_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             tick;
    logic             A_ctp_in;
    logic             B_ctp_in;
    logic             pol_a_A_ctp;
    logic             pol_a_B_ctp;
    logic             pol_b_A_ctp;
    logic             pol_b_B_ctp;
    logic [REF_W-1:0] policy_a_recovery_ref;
    logic [REF_W-1:0] policy_b_recovery_ref;
    logic             A_ctp_out;
    logic             B_ctp_out;
    logic             out_valid;
    logic [1:0]       grant;
    logic             conflict;
    logic [CNT_W-1:0] conflict_count;

    modport master (
        output tick, A_ctp_in, B_ctp_in, pol_a_A_ctp, pol_a_B_ctp,
               pol_b_A_ctp, pol_b_B_ctp, policy_a_recovery_ref, policy_b_recovery_ref,
        input  A_ctp_out, B_ctp_out, out_valid, grant, conflict, conflict_count
    );

    modport slave (
        input  tick, A_ctp_in, B_ctp_in, pol_a_A_ctp, pol_a_B_ctp,
               pol_b_A_ctp, pol_b_B_ctp, policy_a_recovery_ref, policy_b_recovery_ref,
        output A_ctp_out, B_ctp_out, out_valid, grant, conflict, conflict_count
    );
endinterface

// File: rtl/ab_policy_recovery_scheduler.sv
// Arbitrates between two enforcer policies (a, b) editing the same A_ctp/B_ctp channel.
// Each tick selects pass-through, a's edits or b's edits; result is registered one cycle
// later with an out_valid pulse. Disagreeing simultaneous requests are resolved by a
// round-robin pointer, and the winner keeps the grant for up to HOLD_CYCLES ticks.
// Ports: clk, reset (async active-high), bus (slave modport of
// ab_policy_recovery_scheduler_if).
// Optional feature macro: AB_SCHED_STATS_EN enables the saturating conflict_count;
// when undefined conflict_count is tied to 0.
module ab_policy_recovery_scheduler #(
    parameter int unsigned REF_W       = 3,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    ab_policy_recovery_scheduler_if.slave bus
);
    localparam int unsigned HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD_A, S_HOLD_B} state_t;

    state_t          state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            rr_q, rr_d;
    logic            a_q, b_q, valid_q, conflict_q;
    logic [1:0]      grant_q;

    logic            req_a, req_b, agree, idle_eval;
    logic            a_c, b_c, conflict_c;
    logic [1:0]      grant_c;

    assign req_a = |bus.policy_a_recovery_ref;
    assign req_b = |bus.policy_b_recovery_ref;
    assign agree = ({bus.pol_a_A_ctp, bus.pol_a_B_ctp} == {bus.pol_b_A_ctp, bus.pol_b_B_ctp});

    // Next-state and selection for the current tick
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rr_d       = rr_q;
        a_c        = bus.A_ctp_in;
        b_c        = bus.B_ctp_in;
        grant_c    = 2'b00;
        conflict_c = 1'b0;
        idle_eval  = 1'b0;

        case (state_q)
            S_HOLD_A: begin
                if (req_a) begin
                    a_c        = bus.pol_a_A_ctp;
                    b_c        = bus.pol_a_B_ctp;
                    grant_c    = 2'b01;
                    conflict_c = req_b && !agree;
                    hold_d     = hold_q - HC_W'(1);
                    if (hold_q == HC_W'(1)) state_d = S_IDLE;
                end else begin
                    idle_eval = 1'b1;
                end
            end
            S_HOLD_B: begin
                if (req_b) begin
                    a_c        = bus.pol_b_A_ctp;
                    b_c        = bus.pol_b_B_ctp;
                    grant_c    = 2'b10;
                    conflict_c = req_a && !agree;
                    hold_d     = hold_q - HC_W'(1);
                    if (hold_q == HC_W'(1)) state_d = S_IDLE;
                end else begin
                    idle_eval = 1'b1;
                end
            end
            default: idle_eval = 1'b1;
        endcase

        // Holder released (or already idle): apply the idle rules on this same tick
        if (idle_eval) begin
            state_d = S_IDLE;
            hold_d  = '0;
            if (req_a && req_b) begin
                if (agree) begin
                    a_c     = bus.pol_a_A_ctp;
                    b_c     = bus.pol_a_B_ctp;
                    grant_c = 2'b11;
                end else begin
                    conflict_c = 1'b1;
                    rr_d       = ~rr_q;
                    a_c        = rr_q ? bus.pol_b_A_ctp : bus.pol_a_A_ctp;
                    b_c        = rr_q ? bus.pol_b_B_ctp : bus.pol_a_B_ctp;
                    grant_c    = rr_q ? 2'b10 : 2'b01;
                    if (HOLD_CYCLES > 1) begin
                        state_d = rr_q ? S_HOLD_B : S_HOLD_A;
                        hold_d  = HOLD_INIT;
                    end
                end
            end else if (req_a) begin
                a_c     = bus.pol_a_A_ctp;
                b_c     = bus.pol_a_B_ctp;
                grant_c = 2'b01;
            end else if (req_b) begin
                a_c     = bus.pol_b_A_ctp;
                b_c     = bus.pol_b_B_ctp;
                grant_c = 2'b10;
            end
        end
    end

    // State and registered result; everything holds between ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            rr_q       <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            valid_q    <= 1'b0;
            grant_q    <= 2'b00;
            conflict_q <= 1'b0;
        end else if (bus.tick) begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rr_q       <= rr_d;
            a_q        <= a_c;
            b_q        <= b_c;
            valid_q    <= 1'b1;
            grant_q    <= grant_c;
            conflict_q <= conflict_c;
        end else begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.A_ctp_out = a_q;
    assign bus.B_ctp_out = b_q;
    assign bus.out_valid = valid_q;
    assign bus.grant     = grant_q;
    assign bus.conflict  = conflict_q;

`ifdef AB_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of conflict ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.tick && conflict_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.conflict_count = cnt_q;
`else
    assign bus.conflict_count = '0;
`endif
endmodule

// File: tb/tb_ab_policy_recovery_scheduler.sv
// Directed self-checking bench for ab_policy_recovery_scheduler (HOLD_CYCLES=2).
module tb_ab_policy_recovery_scheduler;
    localparam int unsigned REF_W = 3;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ab_policy_recovery_scheduler_if #(.REF_W(REF_W), .CNT_W(CNT_W)) bus ();

    ab_policy_recovery_scheduler #(.REF_W(REF_W), .HOLD_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected counter value depends on whether the stats feature is built in
    function automatic logic [31:0] ecnt(input int n);
`ifdef AB_SCHED_STATS_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output check: {A,B}, grant, conflict, out_valid, count
    task automatic chk_all(input string tag, input logic [1:0] ab, input logic [1:0] g,
                           input logic c, input logic v, input int n);
        chk({tag, ".ab"},       32'({bus.A_ctp_out, bus.B_ctp_out}), 32'(ab));
        chk({tag, ".grant"},    32'(bus.grant), 32'(g));
        chk({tag, ".conflict"}, 32'(bus.conflict), 32'(c));
        chk({tag, ".valid"},    32'(bus.out_valid), 32'(v));
        chk({tag, ".count"},    32'(bus.conflict_count), ecnt(n));
    endtask

    // One tick; pa/pb are {A,B} edits, raw is {A_in,B_in}. Returns at the following negedge.
    task automatic do_tick(input logic [2:0] ra, input logic [2:0] rb,
                           input logic [1:0] pa, input logic [1:0] pb, input logic [1:0] raw);
        @(negedge clk);
        bus.policy_a_recovery_ref = ra;
        bus.policy_b_recovery_ref = rb;
        {bus.pol_a_A_ctp, bus.pol_a_B_ctp} = pa;
        {bus.pol_b_A_ctp, bus.pol_b_B_ctp} = pb;
        {bus.A_ctp_in, bus.B_ctp_in} = raw;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.A_ctp_in = 1'b0;
        bus.B_ctp_in = 1'b0;
        bus.pol_a_A_ctp = 1'b0;
        bus.pol_a_B_ctp = 1'b0;
        bus.pol_b_A_ctp = 1'b0;
        bus.pol_b_B_ctp = 1'b0;
        bus.policy_a_recovery_ref = '0;
        bus.policy_b_recovery_ref = '0;
        repeat (2) @(negedge clk);
        chk_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 0);
        reset = 1'b0;

        // No request: raw pass-through
        do_tick(3'd0, 3'd0, 2'b00, 2'b00, 2'b10);
        chk_all("pass", 2'b10, 2'b00, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk_all("idle_hold", 2'b10, 2'b00, 1'b0, 1'b0, 0);

        // Single request from a
        do_tick(3'd3, 3'd0, 2'b01, 2'b00, 2'b10);
        chk_all("only_a", 2'b01, 2'b01, 1'b0, 1'b1, 0);

        // Disagreeing conflict, HOLD=2: grants a, a, b
        do_tick(3'd1, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("conf1", 2'b10, 2'b01, 1'b1, 1'b1, 1);
        do_tick(3'd1, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("conf2", 2'b10, 2'b01, 1'b1, 1'b1, 2);
        do_tick(3'd1, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("conf3", 2'b01, 2'b10, 1'b1, 1'b1, 3);

        // Still holding for b: agreeing edits still grant b alone, then hold ends
        do_tick(3'd1, 3'd2, 2'b11, 2'b11, 2'b00);
        chk_all("hold_b_agree", 2'b11, 2'b10, 1'b0, 1'b1, 3);
        // Back in IDLE: agreement grants both
        do_tick(3'd1, 3'd2, 2'b11, 2'b11, 2'b00);
        chk_all("agree", 2'b11, 2'b11, 1'b0, 1'b1, 3);

        // rr_ptr back at a: conflict enters HOLD_A
        do_tick(3'd1, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("conf4", 2'b10, 2'b01, 1'b1, 1'b1, 4);
        // a drops its request while holding: b granted on the same tick
        do_tick(3'd0, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("release", 2'b01, 2'b10, 1'b0, 1'b1, 4);
        // Idle again with rr_ptr at b: conflict goes to b and enters HOLD_B
        do_tick(3'd1, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("conf5", 2'b01, 2'b10, 1'b1, 1'b1, 5);

        // Asynchronous reset while in HOLD_B
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("mid_reset", 2'b00, 2'b00, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        // Pointer restored: a wins the next conflict from IDLE
        do_tick(3'd1, 3'd2, 2'b10, 2'b01, 2'b00);
        chk_all("post_reset", 2'b10, 2'b01, 1'b1, 1'b1, 1);

        // Counter saturation after many conflict ticks
        for (int i = 0; i < 260; i++) begin
            do_tick(3'd4, 3'd5, 2'b10, 2'b01, 2'b00);
        end
        chk("saturate", 32'(bus.conflict_count), ecnt(255));
        chk("sat_conflict", 32'(bus.conflict), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
